// File: rtl/sum3_share_pkg.sv
// Shared types and helpers for the sum3_share_ctrl block.
//   state_t    : controller FSM states
//   DW_DEFAULT : default operand/sum width of the summing engine
//   clog2      : ceiling log2 for sizing index and counter fields
package sum3_share_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    WAIT = 3'd4,
    RESP = 3'd5
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sum3_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set bit of req scanning upward
// from rr_ptr with wrap-around.
//   req     : request vector
//   rr_ptr  : index with highest priority this round
//   idx_c   : selected requester (0 when nothing is requesting)
//   valid_c : at least one request is set
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   idx_c,
  output logic            valid_c
);

  logic [IW-1:0] cand;

  // Walk the ring from rr_ptr; the first hit wins.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NREQ);
      if (!valid_c && req[cand]) begin
        idx_c   = cand;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum3_share_ctrl.sv
// Round-robin controller sharing one 3-operand summing engine among NREQ
// requesters, with a watchdog that completes a hung transaction with err=1.
//   clk, reset          : clock, asynchronous active-high reset
//   req, req_ops        : request levels and per-requester operand triplets
//   done, err, sum_out  : one-hot completion strobe, timeout flag, result
//   gnt_id, busy        : current/last grant index, controller not idle
//   acc_start, acc_d    : engine start pulse and serial operand bus
//   acc_ready, acc_sum  : engine result strobe and result
module sum3_share_ctrl
  import sum3_share_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*3*DW-1:0]       req_ops,
  output logic [NREQ-1:0]            done,
  output logic                       err,
  output logic [DW-1:0]              sum_out,
  output logic [clog2(NREQ)-1:0]     gnt_id,
  output logic                       busy,
  output logic                       acc_start,
  output logic [DW-1:0]              acc_d,
  input  logic                       acc_ready,
  input  logic [DW-1:0]              acc_sum
);

  localparam int unsigned IW  = clog2(NREQ);
  localparam int unsigned CW  = clog2(TIMEOUT);
  localparam int unsigned OPW = 3 * DW;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  ops_q, ops_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [OPW-1:0]  sel_ops;
  logic            tmo_c;

  // Next values of the registered outputs
  logic [NREQ-1:0] done_d;
  logic            err_d;
  logic [DW-1:0]   sum_d;
  logic [IW-1:0]   gnt_d;
  logic            busy_d;
  logic            start_d;
  logic [DW-1:0]   accd_d;

  // Per-requester operand view of the flat input bus.
  logic [OPW-1:0] ops_arr [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign ops_arr[gi] = req_ops[gi*OPW +: OPW];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  assign sel_ops = ops_arr[pick_idx];
  assign tmo_c   = (cnt_q == CW'(TIMEOUT - 1));

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt_q     <= '0;
      ops_q     <= '0;
      done      <= '0;
      err       <= 1'b0;
      sum_out   <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      acc_start <= 1'b0;
      acc_d     <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_d;
      cnt_q     <= cnt_d;
      ops_q     <= ops_d;
      done      <= done_d;
      err       <= err_d;
      sum_out   <= sum_d;
      gnt_id    <= gnt_d;
      busy      <= busy_d;
      acc_start <= start_d;
      acc_d     <= accd_d;
    end
  end

  // Next-state logic; acc_ready takes priority over an expiring watchdog.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = S0;
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = WAIT;
      WAIT:    if (acc_ready || tmo_c) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values. Outputs are registered, so each value is
  // computed one cycle ahead of the state in which it must appear.
  always_comb begin
    done_d  = '0;
    err_d   = err;
    sum_d   = sum_out;
    gnt_d   = gnt_id;
    busy_d  = (state_nxt != IDLE);
    start_d = 1'b0;
    accd_d  = '0;
    ops_d   = ops_q;
    cnt_d   = cnt_q;
    rr_d    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          ops_d   = sel_ops;
          start_d = 1'b1;
          accd_d  = sel_ops[0 +: DW];
        end
      end
      S0: accd_d = ops_q[DW +: DW];
      S1: accd_d = ops_q[2*DW +: DW];
      S2: cnt_d  = '0;
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (acc_ready) begin
          sum_d          = acc_sum;
          err_d          = 1'b0;
          done_d[gnt_id] = 1'b1;
        end else if (tmo_c) begin
          sum_d          = '0;
          err_d          = 1'b1;
          done_d[gnt_id] = 1'b1;
        end
      end
      RESP: begin
        // Completed requester drops to lowest priority for the next round.
        if (gnt_id == IW'(NREQ - 1)) rr_d = '0;
        else                         rr_d = gnt_id + IW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sum3_share_ctrl.md
Name: sum3_share_ctrl

Overview:
- Round-robin controller that shares one 3-operand summing engine among NREQ requesters.
- Owns the engine's `start`/`d` sequencing and captures its `sum` on `ready`.
- Returns each result to the granted requester with a one-cycle done strobe.
- Includes a timeout watchdog so a hung engine cannot deadlock the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand/sum width (matches engine).
- TIMEOUT, 64, max cycles in WAIT before error completion (≥4).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_ops  in  NREQ*3*DW  operands; requester i uses slice [i*3*DW +: 3*DW], op0 in LSBs; held stable while req[i]=1.
- done  out  NREQ  one-cycle completion strobe, one-hot.
- err  out  1  valid with done; 1 = timeout completion.
- sum_out  out  DW  result, valid with done.
- gnt_id  out  clog2(NREQ)  index of current/last grant.
- busy  out  1  high in any state other than IDLE.
- acc_start  out  1  engine start pulse.
- acc_d  out  DW  engine operand bus.
- acc_ready  in  1  engine result strobe.
- acc_sum  in  DW  engine result.

Behaviour:
- Engine contract:
  - acc_start is high for exactly one cycle, with op0 on acc_d that same cycle.
  - op1 and op2 follow on the next two cycles.
  - The engine later pulses acc_ready with acc_sum.
  - Sum is modulo 2^DW; the controller performs no arithmetic.
- Reset: all outputs are registered and clear to 0 while reset=1, asynchronously. State → IDLE, rr pointer → 0, timeout counter → 0.
- States and transitions:
  - IDLE: if |req, select the first set bit scanning from rr_ptr upward with wrap. Latch the index to gnt_id and latch that requester's 3 operands. → S0.
  - S0: acc_start=1, acc_d=op0. → S1.
  - S1: acc_start=0, acc_d=op1. → S2.
  - S2: acc_d=op2. → WAIT, clear the counter.
  - WAIT: acc_d=0.
    - On acc_ready: capture acc_sum → RESP.
    - Otherwise, when the counter reaches TIMEOUT-1: sum=0, err=1 → RESP.
  - RESP: done[gnt_id]=1, err valid, sum_out valid (sum_out holds until the next RESP). rr_ptr = gnt_id+1 (mod NREQ). → IDLE.
- Latency:
  - req seen in IDLE at cycle T → acc_start at T+1.
  - acc_ready at cycle R → done at R+1.
  - Minimum idle-to-done is 5 cycles with an immediate engine response.
- Operands are latched at grant; later req_ops changes do not affect the transaction in flight.
- req deasserted mid-transaction: the transaction still completes and done still pulses.
- Requesters drop req in the cycle they see done; IDLE samples req one cycle after RESP.
- acc_ready outside WAIT is ignored.
- acc_ready in the same cycle the timeout expires: acc_ready wins and err=0.
- Fairness: a requester holding req continuously cannot be granted twice while another requester is pending.
- Reset mid-transaction: immediate return to IDLE. No done is issued, and acc_start/acc_d clear.

Decomposition:
- Package sum3_share_pkg holds:
  - state enum {IDLE, S0, S1, S2, WAIT, RESP};
  - DW default;
  - function clog2.
- One sub-module: rr_pick, a combinational round-robin priority selector (req, rr_ptr → index, valid).
- The FSM, operand latch and watchdog stay in the top module.

Test Plan:
- Bench setup: engine model replies with the sum 2 cycles after op2 unless disabled.
- Single request:
  - Stimulus: req[2] with ops 0x10, 0x20, 0x30.
  - Response: acc_start one cycle; acc_d sequence 0x10, 0x20, 0x30; done[2] with sum_out=0x60, err=0.
- Contention:
  - Stimulus: req=4'b1111 held continuously after reset.
  - Response: grant order 0, 1, 2, 3, 0; exactly one done bit per RESP.
- Wrap:
  - Stimulus: ops 0xFF, 0x01, 0x01.
  - Response: sum_out=0x01, err=0.
- Timeout:
  - Stimulus: engine disabled; req[1] asserted.
  - Response: done[1] with err=1 and sum_out=0 at TIMEOUT cycles after entering WAIT; busy falls the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset during S1.
  - Response: all outputs 0 asynchronously; no done. After release, the pending req[3] is granted first (rr_ptr=0 scan) and completes normally.
- Tie at timeout:
  - Stimulus: acc_ready asserted on the timeout-expiry cycle.
  - Response: err=0 and sum_out=acc_sum.
